// File: rtl/sr_cmd_arbiter.sv
// sr_cmd_arbiter: debounces raw set/clear request levels, edge-detects them and issues
// arbitrated one-cycle s/r pulses with a hold-off. Optional macro SR_CMD_ARB_SYNC_EN adds a 2-flop input synchronizer.

module sr_cmd_db #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise
);
  logic             filt;
  logic [CNT_W-1:0] cnt;
  logic             last;

  assign last = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  // Filtered level is about to go 0->1 on this edge.
  assign rise = raw && !filt && last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (raw == filt) begin
      cnt <= '0;
    end else if (last) begin
      cnt  <= '0;
      filt <= raw;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module sr_cmd_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 2,
  parameter int CNT_W           = 4,
  parameter int CLR_PRIORITY    = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic conflict,
  output logic busy
);
  localparam int NUM_CH = 2;  // [0] = set, [1] = clear

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  logic [NUM_CH-1:0] req, samp, rise, pend;
  logic              tie, pick_clr;
  state_t            state;
  logic [CNT_W-1:0]  hold_cnt;

  assign req = {clr_req, set_req};

`ifdef SR_CMD_ARB_SYNC_EN
  logic [1:0][NUM_CH-1:0] sync_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], req};
  end
  assign samp = sync_q[1];
`else
  assign samp = req;
`endif

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sr_cmd_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
        .clock (clock),
        .reset (reset),
        .raw   (samp[i]),
        .rise  (rise[i])
      );
    end
  endgenerate

  assign tie      = &pend;
  assign pick_clr = pend[1] && ((CLR_PRIORITY != 0) || !pend[0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pend     <= '0;
      hold_cnt <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
      busy     <= 1'b0;
    end else begin
      pend <= pend | rise;
      case (state)
        IDLE: begin
          if (|pend) begin
            // Winner and any tie loser are both retired; only fresh rises survive.
            pend     <= rise;
            s        <= !pick_clr;
            r        <= pick_clr;
            conflict <= tie;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          s        <= 1'b0;
          r        <= 1'b0;
          conflict <= 1'b0;
          hold_cnt <= CNT_W'(HOLDOFF_CYCLES);
          if (HOLDOFF_CYCLES == 0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt <= CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Self-checking bench for sr_cmd_arbiter: directed scenarios plus random stimulus against a
// window-based reference model; honours SR_CMD_ARB_SYNC_EN when defined.
`timescale 1ns/1ps
module tb_sr_cmd_arbiter;
  localparam int D  = 4;
  localparam int H  = 2;
  localparam int CW = 4;
  localparam int CP = 1;
`ifdef SR_CMD_ARB_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clock = 1'b0, reset = 1'b1, set_req = 1'b0, clr_req = 1'b0;
  logic s, r, conflict, busy;
  int   n_checks = 0, n_fail = 0;

  always #5 clock = ~clock;

  sr_cmd_arbiter #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H), .CNT_W(CW), .CLR_PRIORITY(CP)) dut (
    .clock(clock), .reset(reset), .set_req(set_req), .clr_req(clr_req),
    .s(s), .r(r), .conflict(conflict), .busy(busy)
  );

  // Reference model: a level toggles once the last D samples since reset all differ from it;
  // grants are spaced by H+2 edges and busy covers the grant edge plus H more.
  logic [1:0] m_hist[$];
  logic [1:0] m_filt, m_pend, m_samp, m_sync0, m_sync1;
  int         m_edge, m_ready, m_gnt;
  logic       m_s, m_r, m_cf, m_busy;
  bit         diff_all;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_hist.delete();
      m_filt = '0; m_pend = '0; m_sync0 = '0; m_sync1 = '0;
      m_edge = 0; m_ready = 0; m_gnt = -1000;
      m_s = 0; m_r = 0; m_cf = 0; m_busy = 0;
    end else begin
      m_edge++;
      m_s = 0; m_r = 0; m_cf = 0;
      if (m_pend != 0 && m_edge >= m_ready) begin
        m_cf = (m_pend == 2'b11);
        if (m_pend[1] && (CP != 0 || !m_pend[0])) m_r = 1;
        else m_s = 1;
        m_pend  = '0;
        m_gnt   = m_edge;
        m_ready = m_edge + H + 2;
      end
      m_busy = (m_edge - m_gnt) <= H;
`ifdef SR_CMD_ARB_SYNC_EN
      m_samp  = m_sync1;
      m_sync1 = m_sync0;
      m_sync0 = {clr_req, set_req};
`else
      m_samp = {clr_req, set_req};
`endif
      m_hist.push_back(m_samp);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      for (int c = 0; c < 2; c++) begin
        diff_all = (m_hist.size() == D);
        foreach (m_hist[j]) if (m_hist[j][c] == m_filt[c]) diff_all = 0;
        if (diff_all) begin
          if (!m_filt[c]) m_pend[c] = 1'b1;
          m_filt[c] = ~m_filt[c];
        end
      end
    end
  end

  // Invariants watched in every cycle of every scenario.
  logic prev_s = 1'b0, prev_r = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      n_checks++;
      if (s && r) begin
        n_fail++; $display("FAIL s_and_r t=%0t: s=%b r=%b, required not both 1", $time, s, r);
      end
      n_checks++;
      if ((s && prev_s) || (r && prev_r)) begin
        n_fail++; $display("FAIL pulse_width t=%0t: s=%b/%b r=%b/%b, required single-cycle pulses", $time, prev_s, s, prev_r, r);
      end
      n_checks++;
      if (conflict && !(s || r)) begin
        n_fail++; $display("FAIL conflict_alone t=%0t: conflict=1 with s=r=0", $time);
      end
      prev_s = s; prev_r = r;
    end else begin
      prev_s = 1'b0; prev_r = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; set_req = 1'b0; clr_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; set_req = 1'b1; clr_req = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if ({s, r, conflict, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs: got s,r,conflict,busy=%b required 0000", {s, r, conflict, busy});
    end
    do_reset();
    tick();
    n_checks++;
    if ({s, r, conflict, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_release: got %b required 0000", {s, r, conflict, busy});
    end
  endtask

  task automatic test_single_set();
    do_reset();
    set_req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      n_checks++;
      if (s !== (k == 5 + L)) begin
        n_fail++; $display("FAIL single_set.s edge %0d: got %b required %b", k, s, (k == 5 + L));
      end
      n_checks++;
      if (r !== 1'b0) begin
        n_fail++; $display("FAIL single_set.r edge %0d: got %b required 0", k, r);
      end
      n_checks++;
      if (busy !== (k >= 5 + L && k <= 7 + L)) begin
        n_fail++; $display("FAIL single_set.busy edge %0d: got %b required %b", k, busy, (k >= 5 + L && k <= 7 + L));
      end
    end
    set_req = 1'b0;
  endtask

  task automatic test_short_glitch();
    do_reset();
    set_req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 3) set_req = 1'b0;
      n_checks++;
      if ({s, r, busy} !== 3'b000) begin
        n_fail++; $display("FAIL short_glitch edge %0d: got s,r,busy=%b required 000", k, {s, r, busy});
      end
    end
  endtask

  task automatic test_tie();
    do_reset();
    set_req = 1'b1; clr_req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      n_checks++;
      if (r !== (k == 5 + L) || conflict !== (k == 5 + L)) begin
        n_fail++; $display("FAIL tie.r_conflict edge %0d: got r=%b conflict=%b required %b", k, r, conflict, (k == 5 + L));
      end
      n_checks++;
      if (s !== 1'b0) begin
        n_fail++; $display("FAIL tie.s edge %0d: got %b required 0", k, s);
      end
    end
    set_req = 1'b0; clr_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 2) clr_req = 1'b1;
      n_checks++;
      if (s !== (k == 5 + L)) begin
        n_fail++; $display("FAIL b2b.s edge %0d: got %b required %b", k, s, (k == 5 + L));
      end
      n_checks++;
      if (r !== (k == 9 + L)) begin
        n_fail++; $display("FAIL b2b.r edge %0d: got %b required %b", k, r, (k == 9 + L));
      end
      n_checks++;
      if (conflict !== 1'b0) begin
        n_fail++; $display("FAIL b2b.conflict edge %0d: got %b required 0", k, conflict);
      end
    end
    set_req = 1'b0; clr_req = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    set_req = 1'b1;
    repeat (5 + L) tick();
    n_checks++;
    if (s !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset.pre_s: got %b required 1", s);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (s !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset.async: got s=%b busy=%b required 0 0", s, busy);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if (s !== (k == 5 + L)) begin
        n_fail++; $display("FAIL mid_reset.repulse edge %0d: got %b required %b", k, s, (k == 5 + L));
      end
    end
    set_req = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 5) == 0) set_req = ~set_req;
      if ($urandom_range(0, 5) == 0) clr_req = ~clr_req;
      tick();
      n_checks++;
      if ({s, r, conflict, busy} !== {m_s, m_r, m_cf, m_busy}) begin
        n_fail++;
        $display("FAIL random cycle %0d: got s,r,conflict,busy=%b required %b", k, {s, r, conflict, busy}, {m_s, m_r, m_cf, m_busy});
      end
    end
    set_req = 1'b0; clr_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_short_glitch();
    test_tie();
    test_back_to_back();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
